// File: rtl/mii_checker.sv
`timescale 1ns/1ps
// mii_checker
//   Receive-side frame checker for a 64-bit, 8-lane MII stream (lane 0 is
//   bits [7:0], one control flag per lane). Parses Start/Terminate/Idle
//   control characters, checks preamble/SFD, control placement and length,
//   and forwards frame bytes (destination address through FCS) as 64-bit
//   beats with a contiguous byte-keep mask. Every frame end reports the
//   kept byte count and an error vector.
//
//   Optional feature macro: MII_CHECKER_STATS_EN
//     defined     -> good/bad frame counters are built
//     not defined -> o_good_cnt/o_bad_cnt tied to 0, i_stats_clr ignored
//
// Ports
//   clk            clock, rising edge
//   i_rst          synchronous active-high reset
//   i_valid        qualifies i_mii_rx_d / i_mii_rx_ctrl; low = hold state
//   i_mii_rx_d     64-bit lane data
//   i_mii_rx_ctrl  per-lane control flag (bit n covers bits [8n+7:8n])
//   i_stats_clr    clears the statistics counters
//   o_valid        output beat valid
//   o_data         frame bytes, lane 0 earliest (unkept lanes read 0)
//   o_keep         valid lanes, contiguous from lane 0
//   o_sof/o_eof    first / last beat of a frame
//   o_frame_len    frame byte count, valid with o_eof
//   o_err          [0] preamble/SFD [1] control [2] runt [3] oversize
//                  [4] missing terminate; valid with o_eof
//   o_good_cnt     frames ending with o_err == 0
//   o_bad_cnt      frames ending with o_err != 0
module mii_checker #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_ctrl,
  input  logic        i_stats_clr,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_frame_len,
  output logic [4:0]  o_err,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt
);

  localparam logic [7:0]  C_START = 8'hFB;
  localparam logic [7:0]  C_TERM  = 8'hFD;
  localparam logic [7:0]  C_IDLE  = 8'h07;
  localparam logic [7:0]  C_PRE   = 8'h55;
  localparam logic [7:0]  C_SFD   = 8'hD5;
  localparam logic [15:0] MIN_B   = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_B   = 16'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Index of the lowest lane with its control flag set; 8 when none.
  function automatic logic [3:0] lowest_ctrl(input logic [7:0] c);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (c[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Mask with the n lowest lanes set (n = 0..8).
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Expand a lane mask to a 64-bit byte mask.
  function automatic logic [63:0] byte_mask(input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  // Well-formed terminate at lane k, where k is already the lowest control
  // lane: FD at lane k, and every lane above it a control Idle.
  function automatic logic is_term(input logic [63:0] d, input logic [7:0] c,
                                   input logic [3:0] k);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) == k)
        ok = (d[8*i +: 8] == C_TERM);
      else if (4'(i) > k)
        ok = ok & c[i] & (d[8*i +: 8] == C_IDLE);
    end
    return ok;
  endfunction

  // Lanes 1..7 of the start word must be data: six preamble bytes then SFD.
  function automatic logic preamble_ok(input logic [63:0] d, input logic [7:0] c);
    return (c[7:1] == 7'd0) && (d[63:8] == {C_SFD, {6{C_PRE}}});
  endfunction

  // DROP ends on any control FD, or on an all-control word.
  function automatic logic drop_exit(input logic [63:0] d, input logic [7:0] c);
    logic hit;
    hit = (c == 8'hFF);
    for (int i = 0; i < 8; i++) begin
      if (c[i] && (d[8*i +: 8] == C_TERM)) hit = 1'b1;
    end
    return hit;
  endfunction

  state_t      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        err_pre_q,  err_pre_d;
  logic        sof_pend_q, sof_pend_d;

  logic        valid_q, valid_d;
  logic [63:0] data_q,  data_d;
  logic [7:0]  keep_q,  keep_d;
  logic        sof_q,   sof_d;
  logic        eof_q,   eof_d;
  logic [15:0] len_q,   len_d;
  logic [4:0]  err_q,   err_d;

  logic        start_w;
  logic        term_w;
  logic [3:0]  low;
  logic [3:0]  n;
  logic [15:0] sum;
  logic        beat;
  logic        beat_eof;
  logic [4:0]  ev;
  logic [7:0]  kmask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_pre_d  = err_pre_q;
    sof_pend_d = sof_pend_q;
    beat       = 1'b0;
    beat_eof   = 1'b0;
    ev         = '0;
    low        = lowest_ctrl(i_mii_rx_ctrl);
    start_w    = i_mii_rx_ctrl[0] && (i_mii_rx_d[7:0] == C_START);
    term_w     = is_term(i_mii_rx_d, i_mii_rx_ctrl, low);
    n          = low;
    sum        = cnt_q + 16'(low);

    if (i_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_w) begin
            err_pre_d  = !preamble_ok(i_mii_rx_d, i_mii_rx_ctrl);
            cnt_d      = '0;
            sof_pend_d = 1'b1;
            state_d    = S_DATA;
          end
        end

        S_DATA: begin
          beat       = 1'b1;
          sof_pend_d = 1'b0;
          if (start_w) begin
            // Frame cut short by a new start: close it empty, begin again.
            n          = 4'd0;
            sum        = cnt_q;
            beat_eof   = 1'b1;
            ev[4]      = 1'b1;
            err_pre_d  = !preamble_ok(i_mii_rx_d, i_mii_rx_ctrl);
            cnt_d      = '0;
            sof_pend_d = 1'b1;
          end else if (sum > MAX_B) begin
            // Keep only the bytes that still fit. A terminate here already
            // ended the frame on the wire, so there is nothing to drop.
            n        = 4'(MAX_B - cnt_q);
            sum      = MAX_B;
            beat_eof = 1'b1;
            ev[3]    = 1'b1;
            ev[1]    = (low != 4'd8) && !term_w;
            state_d  = term_w ? S_IDLE : S_DROP;
          end else if (low == 4'd8) begin
            cnt_d = sum;
          end else if (term_w) begin
            beat_eof = 1'b1;
            state_d  = S_IDLE;
          end else begin
            beat_eof = 1'b1;
            ev[1]    = 1'b1;
            state_d  = S_DROP;
          end
        end

        S_DROP: begin
          if (drop_exit(i_mii_rx_d, i_mii_rx_ctrl)) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end

    kmask   = keep_mask(n);
    valid_d = beat;
    data_d  = beat ? (i_mii_rx_d & byte_mask(kmask)) : 64'd0;
    keep_d  = beat ? kmask : 8'd0;
    sof_d   = beat & sof_pend_q;
    eof_d   = beat_eof;
    len_d   = beat_eof ? sum : 16'd0;
    err_d   = beat_eof ? {ev[4], ev[3], (sum < MIN_B), ev[1], err_pre_q} : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_pre_q  <= 1'b0;
      sof_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      len_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_pre_q  <= err_pre_d;
      sof_pend_q <= sof_pend_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_keep      = keep_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_frame_len = len_q;
  assign o_err       = err_q;

`ifdef MII_CHECKER_STATS_EN
  logic [31:0] good_q, good_d;
  logic [31:0] bad_q,  bad_d;

  // Counts move on the same edge that registers o_eof; a clear wins over a
  // coincident increment.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (i_stats_clr) begin
      good_d = '0;
      bad_d  = '0;
    end else if (beat_eof) begin
      if (err_d == 5'd0) good_d = good_q + 32'd1;
      else               bad_d  = bad_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign o_good_cnt = good_q;
  assign o_bad_cnt  = bad_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = i_stats_clr;
  assign o_good_cnt       = 32'd0;
  assign o_bad_cnt        = 32'd0;
`endif

endmodule
